// File: rtl/mdu_pkg.sv
// Shared MDU constants: default operand width, MDUOp_* opcodes and FSM state encodings.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

package mdu_pkg;

  typedef enum logic [2:0] {
    MDUOp_NOP   = 3'b000,
    MDUOp_MULT  = 3'b001,
    MDUOp_MULTU = 3'b010,
    MDUOp_DIV   = 3'b011,
    MDUOp_DIVU  = 3'b100,
    MDUOp_MTHI  = 3'b101,
    MDUOp_MTLO  = 3'b110,
    MDUOp_MF    = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/mdu_div_core.sv
// Unsigned restoring divider datapath: one quotient bit per step, magnitudes only.
module mdu_div_core #(
  parameter int unsigned WORD_WIDTH = `WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [WORD_WIDTH-1:0] dividend,
  input  logic [WORD_WIDTH-1:0] divisor,
  output logic [WORD_WIDTH-1:0] quo_nxt,
  output logic [WORD_WIDTH-1:0] rem_nxt
);

  logic [WORD_WIDTH-1:0] rem, quo, dvs;
  logic [WORD_WIDTH:0]   sh;
  logic                  ge;

  // Outputs are the post-step values so the caller can commit the final bit on the same edge.
  always_comb begin
    sh      = {rem, quo[WORD_WIDTH-1]};
    ge      = (sh >= {1'b0, dvs});
    rem_nxt = ge ? WORD_WIDTH'(sh - {1'b0, dvs}) : sh[WORD_WIDTH-1:0];
    quo_nxt = {quo[WORD_WIDTH-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem <= '0;
      quo <= '0;
      dvs <= '0;
    end else if (load) begin
      rem <= '0;
      quo <= dividend;
      dvs <= divisor;
    end else if (step) begin
      rem <= rem_nxt;
      quo <= quo_nxt;
    end
  end

endmodule

// File: rtl/mdu.sv
// Iterative multiply/divide unit owning HI/LO. Define MDU_FAST_MUL_EN for a single-cycle multiply.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = `WORD_WIDTH,
  parameter int unsigned CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [WORD_WIDTH-1:0] inA,
  input  logic [WORD_WIDTH-1:0] inB,
  output logic                  busy,
  output logic                  done,
  output logic [WORD_WIDTH-1:0] hi,
  output logic [WORD_WIDTH-1:0] lo
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(WORD_WIDTH - 1);

  mdu_state_e              state, state_nxt;
  mdu_op_e                 opc;
  logic [CNT_WIDTH-1:0]    cnt;
  logic [WORD_WIDTH-1:0]   mcand, a_raw, mag_a, mag_b;
  logic [2*WORD_WIDTH-1:0] prod, prod_nxt, mul_mag, mul_res;
  logic [WORD_WIDTH:0]     sum;
  logic [WORD_WIDTH-1:0]   quo_nxt, rem_nxt, q_fix, r_fix;
  logic                    neg_res, neg_rem, dz, sa, sb, is_signed;
  logic                    div_load, div_step, last;

  assign opc  = mdu_op_e'(op);
  assign busy = (state != ST_IDLE);

  always_comb begin
    is_signed = (opc == MDUOp_MULT) || (opc == MDUOp_DIV);
    sa        = is_signed && inA[WORD_WIDTH-1];
    sb        = is_signed && inB[WORD_WIDTH-1];
    mag_a     = sa ? -inA : inA;
    mag_b     = sb ? -inB : inB;
  end

  // Shift-add: add multiplicand to the upper half when the low bit is set, then shift right.
  always_comb begin
    sum      = {1'b0, prod[2*WORD_WIDTH-1:WORD_WIDTH]} + {1'b0, (prod[0] ? mcand : '0)};
    prod_nxt = {sum, prod[WORD_WIDTH-1:1]};
`ifdef MDU_FAST_MUL_EN
    mul_mag  = {{WORD_WIDTH{1'b0}}, mcand} * {{WORD_WIDTH{1'b0}}, prod[WORD_WIDTH-1:0]};
`else
    mul_mag  = prod_nxt;
`endif
    mul_res  = neg_res ? -mul_mag : mul_mag;
    q_fix    = neg_res ? -quo_nxt : quo_nxt;
    r_fix    = neg_rem ? -rem_nxt : rem_nxt;
  end

  always_comb begin
    state_nxt = state;
    div_load  = 1'b0;
    div_step  = 1'b0;
    last      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          case (opc)
            MDUOp_MULT, MDUOp_MULTU: state_nxt = ST_MUL;
            MDUOp_DIV, MDUOp_DIVU: begin
              state_nxt = ST_DIV;
              div_load  = 1'b1;
            end
            default: state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_MUL: begin
`ifdef MDU_FAST_MUL_EN
        last = 1'b1;
`else
        last = (cnt == LAST);
`endif
        if (last) state_nxt = ST_IDLE;
      end
      ST_DIV: begin
        div_step = 1'b1;
        last     = (cnt == LAST);
        if (last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      cnt     <= '0;
      mcand   <= '0;
      prod    <= '0;
      a_raw   <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dz      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE) begin
        cnt <= '0;
        if (start) begin
          case (opc)
            MDUOp_MULT, MDUOp_MULTU, MDUOp_DIV, MDUOp_DIVU: begin
              mcand   <= mag_a;
              prod    <= {{WORD_WIDTH{1'b0}}, mag_b};
              a_raw   <= inA;
              neg_res <= sa ^ sb;
              neg_rem <= sa;
              dz      <= (inB == '0);
            end
            MDUOp_MTHI: hi <= inA;
            MDUOp_MTLO: lo <= inA;
            default: ;
          endcase
        end
      end else begin
        cnt <= cnt + CNT_WIDTH'(1);
        if (state == ST_MUL) prod <= prod_nxt;
        if (last) begin
          done <= 1'b1;
          if (state == ST_MUL) begin
            {hi, lo} <= mul_res;
          end else begin
            lo <= dz ? '1 : q_fix;
            hi <= dz ? a_raw : r_fix;
          end
        end
      end
    end
  end

  mdu_div_core #(.WORD_WIDTH(WORD_WIDTH)) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .dividend (mag_a),
    .divisor  (mag_b),
    .quo_nxt  (quo_nxt),
    .rem_nxt  (rem_nxt)
  );

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu.
module tb_mdu;
  import mdu_pkg::*;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 32;
`endif
  localparam int DIV_LAT = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] inA = '0, inB = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int tests = 0;
  int failed = 0;

  mdu #(.WORD_WIDTH(32), .CNT_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .inA(inA), .inB(inB),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int exp_cyc, input string tag);
    int cycles;
    start = 1'b1; op = o; inA = a; inB = b;
    tick();
    start = 1'b0;
    cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      tick();
    end
    check({tag, "_latency"}, 64'(cycles), 64'(exp_cyc));
    check({tag, "_done"}, 64'(done), 64'd1);
    tick();
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int cycles;
    logic [31:0] hi_mid;
    logic saw_done;

    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    rst = 1'b0;
    tick();

    run_op(MDUOp_MULT, 32'hFFFFFFFD, 32'd5, MUL_LAT, "mult_neg");
    check("mult_neg_hi", 64'(hi), 64'hFFFFFFFF);
    check("mult_neg_lo", 64'(lo), 64'hFFFFFFF1);

    run_op(MDUOp_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, "multu_max");
    check("multu_max_hi", 64'(hi), 64'hFFFFFFFE);
    check("multu_max_lo", 64'(lo), 64'h00000001);

    run_op(MDUOp_DIV, 32'hFFFFFFF9, 32'd2, DIV_LAT, "div_neg");
    check("div_neg_lo", 64'(lo), 64'hFFFFFFFD);
    check("div_neg_hi", 64'(hi), 64'hFFFFFFFF);

    run_op(MDUOp_DIV, 32'h80000000, 32'hFFFFFFFF, DIV_LAT, "div_ovf");
    check("div_ovf_lo", 64'(lo), 64'h80000000);
    check("div_ovf_hi", 64'(hi), 64'h0);

    run_op(MDUOp_DIVU, 32'd100, 32'd0, DIV_LAT, "divu_dz");
    check("divu_dz_lo", 64'(lo), 64'hFFFFFFFF);
    check("divu_dz_hi", 64'(hi), 64'h00000064);

    run_op(MDUOp_DIV, 32'hFFFFFFF9, 32'd0, DIV_LAT, "div_dz");
    check("div_dz_lo", 64'(lo), 64'hFFFFFFFF);
    check("div_dz_hi", 64'(hi), 64'hFFFFFFF9);

    // MTHI then MTLO on consecutive edges
    start = 1'b1; op = MDUOp_MTHI; inA = 32'h12345678;
    tick();
    check("mthi_hi", 64'(hi), 64'h12345678);
    check("mthi_busy", 64'(busy), 64'd0);
    check("mthi_done", 64'(done), 64'd0);
    op = MDUOp_MTLO; inA = 32'h9ABCDEF0;
    tick();
    start = 1'b0;
    check("mtlo_lo", 64'(lo), 64'h9ABCDEF0);
    check("mtlo_hi_kept", 64'(hi), 64'h12345678);
    check("mtlo_busy", 64'(busy), 64'd0);
    check("mtlo_done", 64'(done), 64'd0);

    // DIVU 7/2 with a stray MTHI request while busy
    start = 1'b1; op = MDUOp_DIVU; inA = 32'd7; inB = 32'd2;
    tick();
    start = 1'b0;
    cycles = 0;
    hi_mid = '0;
    while (busy && cycles < 100) begin
      cycles++;
      if (cycles == 5) begin
        start = 1'b1; op = MDUOp_MTHI; inA = 32'h0000DEAD;
      end else begin
        start = 1'b0;
      end
      tick();
      if (cycles == 10) hi_mid = hi;
    end
    start = 1'b0;
    check("busy_ign_latency", 64'(cycles), 64'(DIV_LAT));
    check("busy_ign_hi_mid", 64'(hi_mid), 64'h12345678);
    check("busy_ign_lo", 64'(lo), 64'd3);
    check("busy_ign_hi", 64'(hi), 64'd1);
    tick();
    check("busy_ign_idle", 64'(busy), 64'd0);

    // Reset mid-multiply: abort, no partial write, no done
    start = 1'b1; op = MDUOp_MULT; inA = 32'd3; inB = 32'd4;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    saw_done = done;
    for (int i = 0; i < 30; i++) begin
      tick();
      saw_done = saw_done | done;
    end
    check("abort_no_done", 64'(saw_done), 64'd0);

    run_op(MDUOp_MULT, 32'd3, 32'd4, MUL_LAT, "mult_small");
    check("mult_small_lo", 64'(lo), 64'd12);
    check("mult_small_hi", 64'(hi), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
